comm_rx_deframer: RTL
=====================

COMM_RX_DEFRAMER -- requirements
Module: comm_rx_deframer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, payload FIFO depth in 32-bit words (power of 2).
REQ-002 Parameter MAX_LEN, default 32, maximum payload bytes per frame.
REQ-003 Parameter TIMEOUT_CYCLES, default 2000, maximum inclk cycles between new_bit_enable pulses inside a frame.
REQ-004 Clock: inclk  in  1  single clock domain; all logic on rising edge.
REQ-005 Reset: reset  in  1  synchronous, active-high.
REQ-006 new_bit_enable  in  1  one-cycle strobe; new_bit is valid this cycle.
REQ-007 new_bit  in  1  decoded line bit, MSB-first within each byte.
REQ-008 start_byte_detected  in  1  one-cycle strobe marking frame start.
REQ-009 word_data  out  32  FIFO head word.
REQ-010 word_valid  out  1  head word is committed and readable.
REQ-011 word_ready  in  1  consumer accepts word_data when word_valid is high.
REQ-012 frame_ok  out  1  one-cycle pulse: frame committed.
REQ-013 frame_err  out  1  one-cycle pulse: frame discarded.
REQ-014 err_code  out  3  reason, held until next frame_err or frame_ok; 0 none, 1 bad length, 2 CRC, 3 timeout, 4 overflow, 5 restart.
REQ-015 fill_level  out  log2(FIFO_DEPTH)+1  count of committed unread words.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, LEN, PAYLOAD, CRC; each bit shifts into an 8-bit shift register on new_bit_enable.
REQ-018 IDLE->LEN on start_byte_detected; strobes other than start_byte_detected are ignored in IDLE.
REQ-019 LEN: after 8 bits, L = byte; L=0 or L>MAX_LEN -> abort code 1; else -> PAYLOAD.
REQ-020 PAYLOAD: bytes packed big-endian (first byte in word_data[31:24]); each full word is written at the speculative write pointer; after L bytes a partial word is written zero-padded in the low bytes; -> CRC.
REQ-021 CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed bitwise over the length byte and payload bytes.
REQ-022 CRC: after 8 bits, match -> commit (committed pointer := speculative pointer), frame_ok pulse, err_code := 0, -> IDLE; mismatch -> abort code 2.
REQ-023 frame_ok/frame_err assert the cycle after the new_bit_enable that carries the deciding bit.
REQ-024 Abort: speculative pointer := committed pointer, frame_err pulse, err_code updated, state := IDLE (except REQ-027).
REQ-025 Timeout: idle counter clears on each new_bit_enable and increments otherwise while busy; reaching TIMEOUT_CYCLES -> abort code 3.
REQ-026 Overflow: a word write when the speculative pointer is FIFO_DEPTH words ahead of the read pointer -> abort code 4; committed data is untouched.
REQ-027 start_byte_detected while busy -> abort code 5, then enter LEN (new frame starts that cycle).
REQ-028 word_valid = (read pointer != committed pointer); word_data is combinational from memory at the read pointer.
REQ-029 word_valid && word_ready advances the read pointer at the next edge; a read and a commit in the same cycle are both honoured.
REQ-030 Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty are decided by the extra MSB.
REQ-031 The output side never exposes uncommitted words.

Reset
REQ-032 On reset the block SHALL reach state IDLE; all pointers, CRC, shift register, counters := 0; word_valid, frame_ok, frame_err, busy := 0; err_code := 0; fill_level := 0.
REQ-033 Reset mid-frame discards the frame and all unread committed words, with no frame_err pulse.

Verification
REQ-034 start, L=0x01, payload 0x00, CRC 0x15 -> frame_ok, word_data=0x00000000, word_valid=1, fill_level=1.
REQ-035 Same frame with CRC 0x16 -> frame_err, err_code=2, word_valid=0, fill_level unchanged.
REQ-036 L=0x21 (MAX_LEN=32) -> frame_err, err_code=1, busy=0 one cycle after the 8th length bit.
REQ-037 word_ready=0, frames of 32 bytes: the 1st and 2nd commit (fill_level=16); the 3rd aborts with err_code=4 and fill_level stays 16.
REQ-038 Bits stop mid-payload for 2000 cycles -> frame_err, err_code=3; a second start mid-frame -> err_code=5 and the next valid frame commits normally.
REQ-039 With word_ready=1 held during a commit, drain 16 words -> pointers wrap and data order matches the send order.

Source files
------------

// File: rtl/comm_rx_deframer.sv
// Receive-side deframer: collects a bit stream into length/payload/CRC bytes,
// stages payload words speculatively in a FIFO and only exposes them to the
// consumer once the frame CRC has been verified.
module comm_rx_deframer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int MAX_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                          inclk,
  input  logic                          reset,
  input  logic                          new_bit_enable,
  input  logic                          new_bit,
  input  logic                          start_byte_detected,
  output logic [31:0]                   word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          frame_ok,
  output logic                          frame_err,
  output logic [2:0]                    err_code,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] FULL_GAP  = PW'(FIFO_DEPTH);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CRC     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVF     = 3'd4;
  localparam logic [2:0] ERR_RESTART = 3'd5;

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CRC} state_t;

  state_t        state;
  logic [6:0]    bit_shift;
  logic [2:0]    bit_cnt;
  logic [7:0]    crc;
  logic [7:0]    len;
  logic [7:0]    byte_cnt;
  logic [1:0]    byte_pos;
  logic [31:0]   word_acc;
  logic [TW-1:0] idle_cnt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] com_ptr;
  logic [PW-1:0] spec_ptr;
  logic [31:0]   mem [FIFO_DEPTH];

  logic [7:0]    next_byte;
  logic [7:0]    crc_next;
  logic [31:0]   packed_word;
  logic [PW-1:0] spec_gap;
  logic          byte_done;
  logic          last_byte;
  logic          word_write_req;
  logic          spec_full;
  logic          mem_we;
  logic          rd_fire;

  assign next_byte      = {bit_shift, new_bit};
  assign crc_next       = {crc[6:0], 1'b0} ^ ((crc[7] ^ new_bit) ? 8'h07 : 8'h00);
  assign byte_done      = new_bit_enable && (bit_cnt == 3'd7);
  assign last_byte      = ((byte_cnt + 8'd1) == len);
  assign word_write_req = (state == PAYLOAD) && byte_done && ((byte_pos == 2'd3) || last_byte);
  assign spec_gap       = spec_ptr - rd_ptr;
  assign spec_full      = (spec_gap == FULL_GAP);
  assign mem_we         = word_write_req && !spec_full && !start_byte_detected && !reset;

  assign word_valid = (rd_ptr != com_ptr);
  assign fill_level = com_ptr - rd_ptr;
  assign word_data  = mem[rd_ptr[AW-1:0]];
  assign busy       = (state != IDLE);
  assign rd_fire    = word_valid && word_ready;

  // Merge the byte just completed into the word being assembled, big-endian.
  always_comb begin
    packed_word = word_acc;
    case (byte_pos)
      2'd0:    packed_word[31:24] = next_byte;
      2'd1:    packed_word[23:16] = next_byte;
      2'd2:    packed_word[15:8]  = next_byte;
      default: packed_word[7:0]   = next_byte;
    endcase
  end

  // Payload storage; words land at the speculative pointer and stay hidden until commit.
  always_ff @(posedge inclk) begin
    if (mem_we) mem[spec_ptr[AW-1:0]] <= packed_word;
  end

  // Frame FSM with CRC, length/overflow/timeout checks and the three FIFO pointers.
  always_ff @(posedge inclk) begin
    if (reset) begin
      state     <= IDLE;
      bit_shift <= '0;
      bit_cnt   <= '0;
      crc       <= '0;
      len       <= '0;
      byte_cnt  <= '0;
      byte_pos  <= '0;
      word_acc  <= '0;
      idle_cnt  <= '0;
      rd_ptr    <= '0;
      com_ptr   <= '0;
      spec_ptr  <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;

      if (start_byte_detected) begin
        if (state != IDLE) begin
          frame_err <= 1'b1;
          err_code  <= ERR_RESTART;
          spec_ptr  <= com_ptr;
        end
        state     <= LEN;
        bit_shift <= '0;
        bit_cnt   <= '0;
        crc       <= '0;
        len       <= '0;
        byte_cnt  <= '0;
        byte_pos  <= '0;
        word_acc  <= '0;
        idle_cnt  <= '0;
      end else if (state != IDLE) begin
        if (new_bit_enable) begin
          idle_cnt  <= '0;
          bit_shift <= next_byte[6:0];
          bit_cnt   <= bit_cnt + 3'd1;
          if (state != CRC) crc <= crc_next;
          if (bit_cnt == 3'd7) begin
            case (state)
              LEN: begin
                if ((next_byte == 8'd0) || (next_byte > MAX_LEN_B)) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_LEN;
                  spec_ptr  <= com_ptr;
                  state     <= IDLE;
                end else begin
                  len   <= next_byte;
                  state <= PAYLOAD;
                end
              end
              PAYLOAD: begin
                byte_cnt <= byte_cnt + 8'd1;
                if (word_write_req) begin
                  if (spec_full) begin
                    frame_err <= 1'b1;
                    err_code  <= ERR_OVF;
                    spec_ptr  <= com_ptr;
                    state     <= IDLE;
                  end else begin
                    spec_ptr <= spec_ptr + 1'b1;
                    word_acc <= '0;
                    byte_pos <= '0;
                    if (last_byte) state <= CRC;
                  end
                end else begin
                  word_acc <= packed_word;
                  byte_pos <= byte_pos + 2'd1;
                end
              end
              CRC: begin
                if (next_byte == crc) begin
                  com_ptr  <= spec_ptr;
                  frame_ok <= 1'b1;
                  err_code <= ERR_NONE;
                end else begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_CRC;
                  spec_ptr  <= com_ptr;
                end
                state <= IDLE;
              end
              default: state <= IDLE;
            endcase
          end
        end else if (idle_cnt == TO_LAST) begin
          frame_err <= 1'b1;
          err_code  <= ERR_TIMEOUT;
          spec_ptr  <= com_ptr;
          state     <= IDLE;
          idle_cnt  <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule
